pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID … MEM/WB).
- Carries one generic payload bus plus a control bus and lock bit.
- Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush that injects a bubble, and a global enable.
- Instantiated between any two CPU stages; payload fields (is, pcout, ra, rb, R, Memdata, p2..p4) are concatenated by the instantiating module.

---
 rtl/pipe_stage_skid.sv | 183 ++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with a valid/ready handshake, 2-entry skid buffer,
// bubble-injecting flush and global enable. Optional statistics counters: define PIPE_STAT_EN.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 192,
    parameter int unsigned CTRL_W = 26,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              in_CLK,
    input  logic              in_CLR,
    input  logic              in_EN,
    input  logic              in_flush,
    input  logic              in_valid,
    output logic              out_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_lock,
    output logic              out_valid,
    input  logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_lock
`ifdef PIPE_STAT_EN
    ,
    output logic [CNT_W-1:0]  out_stall_cnt,
    output logic [CNT_W-1:0]  out_bubble_cnt
`endif
);

    // The state is the pair of valid bits {main, skid}; 01 cannot be reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BAD   = 2'b01,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } state_e;

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic              m_lock_q,  m_lock_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic              s_lock_q,  s_lock_d;

    state_e state_s;
    logic   up_s;
    logic   dn_s;

    assign state_s   = state_e'({m_valid_q, s_valid_q});
    assign out_ready = ~s_valid_q & in_EN;
    assign out_valid = m_valid_q & in_EN;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_valid_q ? m_ctrl_q : {CTRL_W{1'b0}};
    assign out_lock  = m_valid_q ? m_lock_q : 1'b0;
    assign up_s      = in_valid & out_ready;
    assign dn_s      = out_valid & in_ready;

    // Next-state logic for the main and skid entries.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ctrl_d  = m_ctrl_q;
        m_lock_d  = m_lock_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_ctrl_d  = s_ctrl_q;
        s_lock_d  = s_lock_q;
        if (in_flush) begin
            // Bubble injection: payload data is left in place, only control is scrubbed.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_ctrl_d  = {CTRL_W{1'b0}};
            s_ctrl_d  = {CTRL_W{1'b0}};
            m_lock_d  = 1'b0;
            s_lock_d  = 1'b0;
        end else if (in_EN) begin
            case (state_s)
                ST_EMPTY: begin
                    if (up_s) begin
                        m_valid_d = 1'b1;
                        m_data_d  = in_data;
                        m_ctrl_d  = in_ctrl;
                        m_lock_d  = in_lock;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (up_s && dn_s) begin
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                        m_lock_d = in_lock;
                    end else if (dn_s) begin
                        m_valid_d = 1'b0;
                    end else if (up_s) begin
                        s_valid_d = 1'b1;
                        s_data_d  = in_data;
                        s_ctrl_d  = in_ctrl;
                        s_lock_d  = in_lock;
                    end else begin
                        m_valid_d = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (dn_s) begin
                        m_data_d  = s_data_q;
                        m_ctrl_d  = s_ctrl_q;
                        m_lock_d  = s_lock_q;
                        s_valid_d = 1'b0;
                    end else begin
                        s_valid_d = 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to EMPTY rather than emit a stale skid entry.
                    m_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                end
            endcase
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Entry storage with asynchronous clear.
    always_ff @(posedge in_CLK or posedge in_CLR) begin
        if (in_CLR) begin
            m_valid_q <= 1'b0;
            m_data_q  <= {DATA_W{1'b0}};
            m_ctrl_q  <= {CTRL_W{1'b0}};
            m_lock_q  <= 1'b0;
            s_valid_q <= 1'b0;
            s_data_q  <= {DATA_W{1'b0}};
            s_ctrl_q  <= {CTRL_W{1'b0}};
            s_lock_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ctrl_q  <= m_ctrl_d;
            m_lock_q  <= m_lock_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_ctrl_q  <= s_ctrl_d;
            s_lock_q  <= s_lock_d;
        end
    end

`ifdef PIPE_STAT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             stall_inc_s;
    logic             bubble_inc_s;

    assign stall_inc_s    = out_valid & ~in_ready;
    assign bubble_inc_s   = in_EN & ~m_valid_q;
    assign out_stall_cnt  = stall_cnt_q;
    assign out_bubble_cnt = bubble_cnt_q;

    // Saturating statistics counters; only in_CLR clears them.
    always_ff @(posedge in_CLK or posedge in_CLR) begin
        if (in_CLR) begin
            stall_cnt_q  <= {CNT_W{1'b0}};
            bubble_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (bubble_inc_s && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            end else begin
                bubble_cnt_q <= bubble_cnt_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (statistics checks when PIPE_STAT_EN is defined).
module tb_pipe_stage_skid;
    localparam int unsigned DW = 192;
    localparam int unsigned CW = 26;
    localparam int unsigned NW = 16;

    logic          clk = 1'b0;
    logic          clr;
    logic          en;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_lock;
    logic          out_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_lock;
`ifdef PIPE_STAT_EN
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] bubble_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .in_CLK        (clk),
        .in_CLR        (clr),
        .in_EN         (en),
        .in_flush      (flush),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .in_lock       (in_lock),
        .out_valid     (out_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .out_lock      (out_lock)
`ifdef PIPE_STAT_EN
        ,
        .out_stall_cnt (stall_cnt),
        .out_bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic l);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        in_lock  = l;
    endtask

    initial begin
        clr = 1'b1; en = 1'b1; flush = 1'b0; in_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        #2;
        check("rst_valid", 256'(out_valid), 256'h0);
        check("rst_ready", 256'(out_ready), 256'h1);
        check("rst_data",  256'(out_data),  256'h0);
        check("rst_ctrl",  256'(out_ctrl),  256'h0);
        check("rst_lock",  256'(out_lock),  256'h0);
        #10;
        clr = 1'b0;
        step();

        // Streaming: full throughput, one cycle latency
        in_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, DW'(k), CW'(k + 16), k[0]);
            step();
            check("strm_valid", 256'(out_valid), 256'h1);
            check("strm_data",  256'(out_data),  256'(k));
            check("strm_ctrl",  256'(out_ctrl),  256'(k + 16));
            check("strm_lock",  256'(out_lock),  256'(k[0]));
            check("strm_ready", 256'(out_ready), 256'h1);
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("strm_drain", 256'(out_valid), 256'h0);
        check("strm_dctrl", 256'(out_ctrl),  256'h0);

        // Backpressure into the skid entry
        in_ready = 1'b0;
        drive(1'b1, DW'(8'hA), CW'(8'h1A), 1'b0);
        step();
        check("bp_full_data",  256'(out_data),  256'hA);
        check("bp_full_ready", 256'(out_ready), 256'h1);
        drive(1'b1, DW'(8'hB), CW'(8'h1B), 1'b1);
        step();
        check("bp_skid_ready", 256'(out_ready), 256'h0);
        check("bp_skid_data",  256'(out_data),  256'hA);
        check("bp_skid_valid", 256'(out_valid), 256'h1);
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("bp_hold_data",  256'(out_data),  256'hA);
        in_ready = 1'b1;
        #1;
        check("bp_dn_a",       256'(out_data),  256'hA);
        step();
        check("bp_dn_b",       256'(out_data),  256'hB);
        check("bp_dn_b_ctrl",  256'(out_ctrl),  256'h1B);
        check("bp_dn_b_lock",  256'(out_lock),  256'h1);
        check("bp_ready_back", 256'(out_ready), 256'h1);
        step();
        check("bp_empty",      256'(out_valid), 256'h0);

        // Flush in SKID together with a new input
        in_ready = 1'b0;
        drive(1'b1, DW'(8'hC), CW'(8'h2C), 1'b1);
        step();
        drive(1'b1, DW'(8'hD), CW'(8'h2D), 1'b1);
        step();
        check("fl_skid_ready", 256'(out_ready), 256'h0);
        flush = 1'b1;
        drive(1'b1, DW'(8'hE), CW'(8'h2E), 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        check("fl_valid", 256'(out_valid), 256'h0);
        check("fl_ctrl",  256'(out_ctrl),  256'h0);
        check("fl_lock",  256'(out_lock),  256'h0);
        check("fl_ready", 256'(out_ready), 256'h1);
        check("fl_data_held", 256'(out_data), 256'hC);
        in_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("fl_no_output", 256'(out_valid), 256'h0);
        end

        // Enable freeze with an all-ones control word
        in_ready = 1'b0;
        drive(1'b1, DW'(8'h55), {CW{1'b1}}, 1'b1);
        step();
        check("en_full_ctrl", 256'(out_ctrl), 256'h3FFFFFF);
        en = 1'b0;
        drive(1'b1, DW'(8'h66), CW'(8'h66), 1'b0);
        in_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("en_frz_valid", 256'(out_valid), 256'h0);
            check("en_frz_ready", 256'(out_ready), 256'h0);
            step();
        end
        en = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        #1;
        check("en_back_valid", 256'(out_valid), 256'h1);
        check("en_back_data",  256'(out_data),  256'h55);
        check("en_back_ctrl",  256'(out_ctrl),  256'h3FFFFFF);
        check("en_back_lock",  256'(out_lock),  256'h1);
        step();
        check("en_drained", 256'(out_valid), 256'h0);

        // Asynchronous clear mid-cycle while in SKID
        in_ready = 1'b0;
        drive(1'b1, DW'(8'h11), CW'(8'h11), 1'b1);
        step();
        drive(1'b1, DW'(8'h22), CW'(8'h22), 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("clr_pre_ready", 256'(out_ready), 256'h0);
        #2;
        clr = 1'b1;
        #1;
        check("clr_valid", 256'(out_valid), 256'h0);
        check("clr_ctrl",  256'(out_ctrl),  256'h0);
        check("clr_data",  256'(out_data),  256'h0);
        check("clr_lock",  256'(out_lock),  256'h0);
        #3;
        clr = 1'b0;
        step();
        check("clr_ready", 256'(out_ready), 256'h1);
        check("clr_empty", 256'(out_valid), 256'h0);
        drive(1'b1, DW'(8'h77), CW'(8'h07), 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("clr_first_valid", 256'(out_valid), 256'h1);
        check("clr_first_data",  256'(out_data),  256'h77);

`ifdef PIPE_STAT_EN
        // Counters: load cycle is one bubble, then 5 stalls, drain, 2 more bubbles
        clr = 1'b1;
        en = 1'b1;
        in_ready = 1'b0;
        drive(1'b1, DW'(8'h99), CW'(8'h09), 1'b0);
        #2;
        check("st_rst_stall",  256'(stall_cnt),  256'h0);
        check("st_rst_bubble", 256'(bubble_cnt), 256'h0);
        clr = 1'b0;
        step();
        drive(1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 5; k++) step();
        check("st_stall5",  256'(stall_cnt),  256'h5);
        check("st_bubble1", 256'(bubble_cnt), 256'h1);
        in_ready = 1'b1;
        step();
        step();
        step();
        check("st_stall",  256'(stall_cnt),  256'h5);
        check("st_bubble", 256'(bubble_cnt), 256'h3);
        en = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("st_fl_stall",  256'(stall_cnt),  256'h5);
        check("st_fl_bubble", 256'(bubble_cnt), 256'h3);
        clr = 1'b1;
        #1;
        check("st_clr_stall",  256'(stall_cnt),  256'h0);
        check("st_clr_bubble", 256'(bubble_cnt), 256'h0);
        clr = 1'b0;
        en = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
